// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between the serial adder controller and its user.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/serial_add_bit.sv
// One-bit full-adder cell built from two half adders and an OR gate.
module serial_add_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic hs0, hc0, hc1;

  assign hs0 = a_i ^ b_i;
  assign hc0 = a_i & b_i;
  assign s_o = hs0 ^ c_i;
  assign hc1 = hs0 & c_i;
  assign c_o = hc0 | hc1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell time-shared LSB-first over WIDTH bits.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output; otherwise out_ovf is tied low.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_ADD  = 2'(ADD);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_valid_q, out_valid_d;
  logic             bit_s, bit_c;
  logic             last_bit;

  serial_add_bit u_bit (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (bit_s),
    .c_o (bit_c)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.in_a;
          b_sh_d  = bus.in_b;
          carry_d = bus.in_cin;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle registers the result; out_valid rises one cycle after the last bit.
        if (!out_valid_q) begin
          out_sum_d   = sum_sh_q;
          out_cout_d  = carry_q;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is captured while the MSB is being added; overflow = that XOR carry out.
  logic msb_cin_q, msb_cin_d;
  logic out_ovf_q, out_ovf_d;

  always_comb begin
    msb_cin_d = msb_cin_q;
    out_ovf_d = out_ovf_q;
    if (state_q == ST_ADD && last_bit) msb_cin_d = carry_q;
    if (state_q == ST_DONE && !out_valid_q) out_ovf_d = msb_cin_q ^ carry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb_cin_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      msb_cin_q <= msb_cin_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.out_ovf = out_ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed table, corner sequences, random ops.
module tb_serial_add_ctrl;
  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic; overflow when the signed sum leaves the W-bit range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint wide;
    longint sa;
    longint sb;
    longint ss;
    wide = longint'(a) + longint'(b) + longint'(cin);
    s    = W'(wide % (longint'(1) << W));
    co   = (wide >= (longint'(1) << W));
    sa   = $signed(a);
    sb   = $signed(b);
    ss   = sa + sb + longint'(cin);
    ov   = OVF_ON && ((ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1))));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input int stall, input bit glitch, input bit early_rdy);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      bus.out_ready = early_rdy;
      if (glitch && n == 3) begin
        chk({tag, "_busy"}, 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(W + 1));
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_hold_sum"}, 64'(bus.out_sum), 64'(exp_sum));
      chk({tag, "_hold_ready"}, 64'(bus.in_ready), 64'(0));
      @(posedge clk); #1;
    end
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(bus.out_cout), 64'(exp_cout));
    chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(exp_ovf));
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, a, b, cin, bus.out_sum, bus.out_cout, bus.out_ovf, n);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, ec, eo;
    int           n;
    bit           seen;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h03, b: 8'h04, cin: 1'b0, sum: 8'h07, cout: 1'b0, ovf: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_sum", 64'(bus.out_sum), 64'(0));
    chk("rst_out_cout", 64'(bus.out_cout), 64'(0));
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, OVF_ON ? vecs[i].ovf : 1'b0, 0, 1'b0, 1'b0);
    end

    // in_valid pulsed mid-ADD must not disturb the running operation
    run_op("glitch", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    // five cycles of back-pressure in DONE, accept on the sixth
    run_op("stall", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, OVF_ON, 5, 1'b0, 1'b0);

    // reset asserted during the fourth ADD cycle
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_a     = 8'h55;
    bus.in_b     = 8'h22;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_sum", 64'(bus.out_sum), 64'(0));
    chk("mid_rst_cout", 64'(bus.out_cout), 64'(0));
    #2;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_no_partial", 64'(seen), 64'(0));
    run_op("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, es, ec, eo);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, es, ec, eo,
             int'($urandom_range(0, 3)), 1'b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
